// File: rtl/hmac_gen_pkg.sv
// Shared types and constants for the parametrised HMAC sequencer.
package hmac_gen_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIPad,
    StMsg,
    StWaitResp,
    StPushDigest,
    StOPad,
    StDone
  } hmac_st_e;

  typedef enum logic {
    RoundInner,
    RoundOuter
  } round_e;

  typedef enum logic [1:0] {
    SelIPad,
    SelOPad,
    SelFifo
  } rdata_sel_e;

  localparam logic [7:0] IPadByte = 8'h36;
  localparam logic [7:0] OPadByte = 8'h5c;

endpackage

// File: rtl/hmac_key_pad.sv
// Masks the secret key to key_len bytes (MSB first), widens it to a block and XORs the pad byte.
module hmac_key_pad
  import hmac_gen_pkg::*;
#(
  parameter int unsigned KeyBits   = 256,
  parameter int unsigned BlockBits = 512,
  parameter logic [7:0]  PadByte   = IPadByte
) (
  input  logic [KeyBits-1:0]          secret_key,
  input  logic [$clog2(KeyBits/8):0]  key_len,
  output logic [BlockBits-1:0]        pad
);

  logic [BlockBits-1:0] kb;

  always_comb begin
    kb = '0;
    for (int unsigned i = 0; i < KeyBits / 8; i++) begin
      if (i < 32'(key_len)) begin
        kb[BlockBits-1-8*i -: 8] = secret_key[KeyBits-1-8*i -: 8];
      end
    end
    pad = kb ^ {(BlockBits / 8){PadByte}};
  end

endmodule

// File: rtl/hmac_core_gen.sv
// HMAC sequencer between the message FIFO and the SHA-2 engine; transparent when hmac_en is low.
module hmac_core_gen
  import hmac_gen_pkg::*;
#(
  parameter int unsigned WordW       = 32,
  parameter int unsigned BlockBits   = 512,
  parameter int unsigned DigestWords = 8,
  parameter int unsigned KeyBits     = 256,
  parameter int unsigned LenW        = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [KeyBits-1:0]              secret_key,
  input  logic [$clog2(KeyBits/8):0]      key_len,
  input  logic                            hmac_en,
  input  logic                            reg_hash_start,
  input  logic                            reg_hash_process,
  input  logic                            abort_i,
  output logic                            hash_done,
  output logic                            busy,
  output logic                            err_key_len,
  output logic                            sha_hash_start,
  output logic                            sha_hash_process,
  input  logic                            sha_hash_done,
  output logic                            sha_rvalid,
  output logic [WordW-1:0]                sha_rdata,
  output logic [WordW/8-1:0]              sha_rmask,
  input  logic                            sha_rready,
  input  logic                            fifo_rvalid,
  input  logic [WordW-1:0]                fifo_rdata,
  input  logic [WordW/8-1:0]              fifo_rmask,
  output logic                            fifo_rready,
  output logic                            fifo_wsel,
  output logic                            fifo_wvalid,
  output logic [$clog2(DigestWords)-1:0]  fifo_wdata_sel,
  input  logic                            fifo_wready,
  input  logic [LenW-1:0]                 message_length,
  output logic [LenW-1:0]                 sha_message_length
);

  localparam int unsigned SelW        = $clog2(DigestWords);
  localparam int unsigned NumWords    = BlockBits / WordW;
  localparam int unsigned WordIdxW    = $clog2(NumWords);
  localparam int unsigned BitOffW     = $clog2(WordW);
  localparam int unsigned MaxKeyBytes = KeyBits / 8;
  localparam logic [LenW-1:0] BlockLen = LenW'(BlockBits);
  localparam logic [LenW-1:0] WordLen  = LenW'(WordW);
  localparam logic [LenW-1:0] OuterLen = LenW'(BlockBits + DigestWords * WordW);
  localparam logic [SelW-1:0] LastSel  = SelW'(DigestWords - 1);

  hmac_st_e        state_q, state_d;
  round_e          round_q, round_d;
  logic [LenW-1:0] txcount_q, txcount_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic            process_flag_q, process_flag_d;

  logic [BlockBits-1:0] ipad, opad;
  logic [NumWords-1:0][WordW-1:0] ipad_words, opad_words;
  logic [WordIdxW-1:0] word_idx;
  logic [LenW-1:0]     msg_len;
  logic                msg_exit, key_ok, aborting;
  rdata_sel_e          rsel;

  hmac_key_pad #(.KeyBits(KeyBits), .BlockBits(BlockBits), .PadByte(IPadByte)) u_ipad (
    .secret_key (secret_key),
    .key_len    (key_len),
    .pad        (ipad)
  );

  hmac_key_pad #(.KeyBits(KeyBits), .BlockBits(BlockBits), .PadByte(OPadByte)) u_opad (
    .secret_key (secret_key),
    .key_len    (key_len),
    .pad        (opad)
  );

  // Word k sits at the MSB end, so it is packed element NumWords-1-k, i.e. the inverted index.
  assign ipad_words = ipad;
  assign opad_words = opad;
  assign word_idx   = txcount_q[BitOffW +: WordIdxW];

  assign msg_len  = (round_q == RoundInner) ? message_length + BlockLen : OuterLen;
  assign msg_exit = (txcount_q >= msg_len) && ((round_q == RoundOuter) || process_flag_q);
  assign key_ok   = (32'(key_len) <= MaxKeyBytes);
  assign aborting = hmac_en && abort_i && (state_q != StIdle);

  assign busy               = (state_q != StIdle);
  assign fifo_wdata_sel     = sel_q;
  assign sha_message_length = hmac_en ? msg_len : message_length;

  always_comb begin
    sha_hash_start   = 1'b0;
    sha_hash_process = 1'b0;
    hash_done        = 1'b0;
    err_key_len      = 1'b0;
    sha_rvalid       = 1'b0;
    fifo_rready      = 1'b0;
    fifo_wsel        = 1'b0;
    fifo_wvalid      = 1'b0;
    rsel             = SelFifo;
    unique case (state_q)
      StIdle: begin
        if (reg_hash_start) begin
          if (key_ok) sha_hash_start = 1'b1;
          else        err_key_len    = 1'b1;
        end
      end
      StIPad: begin
        rsel       = SelIPad;
        sha_rvalid = (txcount_q != BlockLen);
      end
      StMsg: begin
        if (round_q == RoundInner) sha_hash_process = reg_hash_process;
        if (msg_exit) begin
          if (round_q == RoundOuter) sha_hash_process = 1'b1;
        end else begin
          sha_rvalid  = fifo_rvalid;
          fifo_rready = sha_rready;
        end
      end
      StPushDigest: begin
        fifo_wsel   = 1'b1;
        fifo_wvalid = 1'b1;
        if (fifo_wready && (sel_q == LastSel)) sha_hash_start = 1'b1;
      end
      StOPad: begin
        fifo_wsel  = 1'b1;
        rsel       = SelOPad;
        sha_rvalid = (txcount_q != BlockLen);
      end
      StDone:  hash_done = 1'b1;
      default: ;
    endcase
    if (aborting) begin
      sha_hash_start   = 1'b0;
      sha_hash_process = 1'b0;
      hash_done        = 1'b0;
      sha_rvalid       = 1'b0;
      fifo_rready      = 1'b0;
      fifo_wsel        = 1'b0;
      fifo_wvalid      = 1'b0;
    end
    if (!hmac_en) begin
      sha_hash_start   = reg_hash_start;
      sha_hash_process = reg_hash_process;
      hash_done        = sha_hash_done;
      err_key_len      = 1'b0;
      sha_rvalid       = fifo_rvalid;
      fifo_rready      = sha_rready;
      fifo_wsel        = 1'b0;
      fifo_wvalid      = 1'b0;
      rsel             = SelFifo;
    end
  end

  always_comb begin
    unique case (rsel)
      SelIPad: begin
        sha_rdata = ipad_words[~word_idx];
        sha_rmask = '1;
      end
      SelOPad: begin
        sha_rdata = opad_words[~word_idx];
        sha_rmask = '1;
      end
      default: begin
        sha_rdata = fifo_rdata;
        sha_rmask = fifo_rmask;
      end
    endcase
  end

  always_comb begin
    state_d        = state_q;
    round_d        = round_q;
    sel_d          = '0;
    txcount_d      = (sha_rvalid && sha_rready) ? txcount_q + WordLen : txcount_q;
    process_flag_d = process_flag_q;
    if (reg_hash_start || hash_done || abort_i) process_flag_d = 1'b0;
    if (reg_hash_process)                       process_flag_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (hmac_en && reg_hash_start && key_ok) begin
          state_d   = StIPad;
          round_d   = RoundInner;
          txcount_d = '0;
        end
      end
      StIPad:     if (txcount_q == BlockLen) state_d = StMsg;
      StMsg:      if (msg_exit) state_d = StWaitResp;
      StWaitResp: begin
        if (sha_hash_done) state_d = (round_q == RoundInner) ? StPushDigest : StDone;
      end
      StPushDigest: begin
        sel_d = sel_q;
        if (fifo_wready) begin
          if (sel_q == LastSel) begin
            state_d   = StOPad;
            round_d   = RoundOuter;
            txcount_d = '0;
            sel_d     = '0;
          end else begin
            sel_d = sel_q + SelW'(1);
          end
        end
      end
      StOPad:  if (txcount_q == BlockLen) state_d = StMsg;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (aborting) begin
      state_d        = StIdle;
      txcount_d      = '0;
      sel_d          = '0;
      process_flag_d = 1'b0;
    end
    if (!hmac_en) state_d = StIdle;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      round_q        <= RoundInner;
      txcount_q      <= '0;
      sel_q          <= '0;
      process_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      round_q        <= round_d;
      txcount_q      <= txcount_d;
      sel_q          <= sel_d;
      process_flag_q <= process_flag_d;
    end
  end

endmodule

// File: doc/hmac_core_gen.md
Name: hmac_core_gen

Overview:
Parametrised HMAC sequencer between the message FIFO and the SHA-2 engine. Supports a configurable word width, block size, digest length and key width, so one block serves SHA-256 and SHA-512 HMAC. Compared with the fixed 256-bit version, it adds:
- runtime key-length masking
- a key-length error
- a synchronous abort
- a busy status
With hmac_en low it is a transparent pass-through to the SHA engine.

Parameters:
WordW, 32, SHA word and FIFO data width in bits (32 or 64)
BlockBits, 512, hash block size in bits (512 or 1024); multiple of WordW
DigestWords, 8, digest words pushed back into the FIFO for the outer round (power of two, >=2)
KeyBits, 256, secret_key width; KeyBits <= BlockBits, multiple of 8
LenW, 64, message length width in bits (64 or 128)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
secret_key  in  KeyBits  key, byte 0 at MSB
key_len  in  $clog2(KeyBits/8)+1  valid key bytes, counted from MSB
hmac_en  in  1  1: HMAC sequencing; 0: bypass
reg_hash_start  in  1  start pulse from registers
reg_hash_process  in  1  process pulse from registers
abort_i  in  1  abandon current HMAC operation
hash_done  out  1  completion pulse
busy  out  1  HMAC operation in progress
err_key_len  out  1  one-cycle pulse: start refused, key_len > KeyBits/8
sha_hash_start  out  1  start to SHA engine
sha_hash_process  out  1  process to SHA engine
sha_hash_done  in  1  SHA engine done
sha_rvalid  out  1  word valid to SHA engine
sha_rdata  out  WordW  word data to SHA engine
sha_rmask  out  WordW/8  byte mask to SHA engine
sha_rready  in  1  SHA engine accepts the word
fifo_rvalid  in  1  FIFO word valid
fifo_rdata  in  WordW  FIFO word data
fifo_rmask  in  WordW/8  FIFO byte mask
fifo_rready  out  1  pop FIFO
fifo_wsel  out  1  FIFO write source: 0 register, 1 digest
fifo_wvalid  out  1  digest write request
fifo_wdata_sel  out  $clog2(DigestWords)  digest word index
fifo_wready  in  1  FIFO accepts the write
message_length  in  LenW  message length in bits
sha_message_length  out  LenW  length presented to SHA engine

Behaviour:
- Reset: state Idle, txcount=0, round=Inner, fifo_wdata_sel=0, process_flag=0. All pulse outputs, fifo_wvalid, fifo_wsel and busy are 0.
- Bypass (hmac_en=0): the SHA-side signals are direct copies of the FIFO/register side.
  - sha_hash_start=reg_hash_start, sha_hash_process=reg_hash_process, hash_done=sha_hash_done.
  - sha_rvalid=fifo_rvalid, sha_rdata=fifo_rdata, sha_rmask=fifo_rmask, fifo_rready=sha_rready, sha_message_length=message_length.
  - The FSM stays in Idle.
- Key prep (combinational):
  - kb = secret_key with bytes at index >= key_len forced to 0, zero-extended on the LSB side to BlockBits.
  - ipad = kb ^ {0x36 repeated}; opad = kb ^ {0x5c repeated}.
  - Pad word k = bits [BlockBits-1-WordW*k -: WordW]. Pad mask is all ones.
- txcount (LenW bits, in bits):
  - Adds WordW on each sha_rvalid && sha_rready.
  - Cleared on entry to IPad and to OPad.
  - Wraps modulo 2^LenW.
- sha_message_length:
  - Inner round: message_length + BlockBits, truncated to LenW.
  - Outer round: BlockBits + DigestWords*WordW.
- process_flag: set by reg_hash_process; cleared by reg_hash_start, hash_done or abort. Set takes priority.
- FSM:
  - Idle → IPad on hmac_en && reg_hash_start && key_len <= KeyBits/8. Same cycle: sha_hash_start=1, round=Inner, txcount cleared.
  - If key_len > KeyBits/8: err_key_len=1 for that cycle, no sha_hash_start, stay in Idle.
  - IPad: sha_rvalid=1, data = ipad word; move to Msg once txcount==BlockBits. sha_rvalid=0 in the cycle the count is reached.
  - Msg: sha_rvalid=fifo_rvalid, fifo_rready=sha_rready. Leave for WaitResp when txcount >= sha_message_length and either (Inner && process_flag) or Outer; sha_rvalid=0 that cycle. In the Outer round, sha_hash_process=1 on that transition.
  - Inner-round process: on entry to Msg, the core forwards reg_hash_process straight through as sha_hash_process.
  - WaitResp: on sha_hash_done go to PushDigest if Inner, Done if Outer.
  - PushDigest: fifo_wsel=1, fifo_wvalid=1; fifo_wdata_sel advances on fifo_wready.
    - When fifo_wready && sel==DigestWords-1: go to OPad, sha_hash_start=1, round=Outer, txcount cleared.
    - fifo_wdata_sel is held at 0 in every other state.
  - OPad: as IPad, using opad; fifo_wsel=1 held.
  - Done: hash_done=1 for one cycle, then Idle.
- busy=1 in every state except Idle.
- abort_i (hmac_en=1, not Idle): next state Idle, txcount cleared, process_flag cleared, no hash_done. Abort has priority over every other transition in that cycle. In Idle, abort is ignored.
- reg_hash_start while busy: ignored.
- Reset mid-operation: returns all state to reset values in the next cycle.

Decomposition:
- Package hmac_gen_pkg: state enum, round enum, rdata-select enum, pad byte constants 0x36/0x5c.
- Sub-module hmac_key_pad: combinational masking and XOR, one instance each for ipad and opad, with the pad byte as a parameter.

Test Plan:
- Bypass: hmac_en=0, fifo_rvalid=1, fifo_rdata=0xDEADBEEF → sha_rdata=0xDEADBEEF same cycle; hash_done mirrors sha_hash_done.
- Key masking, WordW=32: key=0x01020304…, key_len=2 → first IPad word 0x37343636, first OPad word 0x5d5e5c5c.
- Full HMAC-SHA256, message_length=64, process pulse during Msg:
  - 16 IPad words, sha_message_length=576.
  - After sha_hash_done, 8 digest writes with fifo_wdata_sel 0..7; OPad issues sha_hash_start; outer sha_message_length=768.
  - hash_done pulses exactly once.
- SHA-512 configuration (WordW=64, BlockBits=1024, LenW=128) → 16 IPad words, outer length 1536.
- key_len=KeyBits/8+1 with reg_hash_start → err_key_len=1 for one cycle, busy stays 0, no sha_hash_start.
- abort_i asserted during PushDigest at sel=3 → Idle next cycle, busy=0, fifo_wvalid=0, no hash_done; a new start then runs the full sequence correctly.
